// File: rtl/cam_frame_capture.sv
// Camera capture front end: sensor master clock, PLK/VS/HS/D synchronisation, luminance
// extraction, fixed-window crop and single-cycle frame RAM write strobes.
module cam_frame_capture #(
  parameter int unsigned XCLK_HALF = 3,
  parameter int unsigned IMG_W     = 96,
  parameter int unsigned IMG_H     = 96,
  parameter int unsigned COL_START = 32,
  parameter int unsigned ROW_START = 12,
  parameter int unsigned Y_PHASE   = 0
) (
  input  logic        Clk,
  input  logic        i_Rst_n,
  input  logic        i_PLK,
  input  logic        i_VS,
  input  logic        i_HS,
  input  logic [7:0]  i_D,
  output logic        o_XLK,
  output logic [7:0]  o_Wr_Data,
  output logic [14:0] o_Wr_Addr,
  output logic        o_Wr_En,
  output logic        o_Frame_Done,
  output logic        o_Frame_Err
);

  localparam logic [3:0]  XCLK_LAST  = 4'(XCLK_HALF - 1);
  localparam logic [13:0] FRAME_SIZE = 14'(IMG_W * IMG_H);
  localparam logic [9:0]  COL_LO     = 10'(COL_START);
  localparam logic [9:0]  COL_HI     = 10'(COL_START + IMG_W);
  localparam logic [9:0]  ROW_LO     = 10'(ROW_START);
  localparam logic [9:0]  ROW_HI     = 10'(ROW_START + IMG_H);
  localparam logic        Y_BIT      = 1'(Y_PHASE);

  typedef enum logic [1:0] {StArm, StVblank, StActive, StDone} state_t;

  state_t      state;
  logic [3:0]  xclk_cnt;
  logic        plk_s1, plk_s2, plk_h;
  logic        vs_s1, vs_s2, vs_h;
  logic        hs_s1, hs_s2, hs_h;
  logic [7:0]  d_p1, d_p2, d_p3;
  logic [9:0]  byte_cnt;
  logic [8:0]  row_cnt;
  logic [13:0] wr_cnt;

  logic        plk_rise, vs_rise, vs_fall, hs_fall;
  logic [8:0]  col;
  logic [9:0]  col_off, row_off;
  logic        col_in, row_in, capture;
  logic [14:0] addr_calc;

  // Free-running master clock, independent of the capture state.
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      xclk_cnt <= 4'd0;
      o_XLK    <= 1'b0;
    end else if (xclk_cnt == XCLK_LAST) begin
      xclk_cnt <= 4'd0;
      o_XLK    <= ~o_XLK;
    end else begin
      xclk_cnt <= xclk_cnt + 4'd1;
    end
  end

  // Two-flop synchronisers plus history flop; data delayed to line up with the PLK edge.
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      plk_s1 <= 1'b0;
      plk_s2 <= 1'b0;
      plk_h  <= 1'b0;
      vs_s1  <= 1'b0;
      vs_s2  <= 1'b0;
      vs_h   <= 1'b0;
      hs_s1  <= 1'b0;
      hs_s2  <= 1'b0;
      hs_h   <= 1'b0;
      d_p1   <= 8'd0;
      d_p2   <= 8'd0;
      d_p3   <= 8'd0;
    end else begin
      plk_s1 <= i_PLK;
      plk_s2 <= plk_s1;
      plk_h  <= plk_s2;
      vs_s1  <= i_VS;
      vs_s2  <= vs_s1;
      vs_h   <= vs_s2;
      hs_s1  <= i_HS;
      hs_s2  <= hs_s1;
      hs_h   <= hs_s2;
      d_p1   <= i_D;
      d_p2   <= d_p1;
      d_p3   <= d_p2;
    end
  end

  assign plk_rise = plk_s2 & ~plk_h;
  assign vs_rise  = vs_s2 & ~vs_h;
  assign vs_fall  = ~vs_s2 & vs_h;
  assign hs_fall  = ~hs_s2 & hs_h;

  // Address comes from the counters so a dropped byte never shifts later pixels.
  always_comb begin
    col       = byte_cnt[9:1];
    col_in    = ({1'b0, col} >= COL_LO) && ({1'b0, col} < COL_HI);
    row_in    = ({1'b0, row_cnt} >= ROW_LO) && ({1'b0, row_cnt} < ROW_HI);
    col_off   = {1'b0, col} - COL_LO;
    row_off   = {1'b0, row_cnt} - ROW_LO;
    addr_calc = 15'(row_off) * 15'(IMG_W) + 15'(col_off);
    capture   = (byte_cnt[0] == Y_BIT) && col_in && row_in;
  end

  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= StArm;
      byte_cnt     <= 10'd0;
      row_cnt      <= 9'd0;
      wr_cnt       <= 14'd0;
      o_Wr_En      <= 1'b0;
      o_Wr_Data    <= 8'd0;
      o_Wr_Addr    <= 15'd0;
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      o_Wr_En      <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
      unique case (state)
        StArm: begin
          // Wait for blanking so a partial frame after reset is discarded.
          if (vs_rise) state <= StVblank;
        end
        StVblank: begin
          if (vs_fall) begin
            row_cnt  <= 9'd0;
            byte_cnt <= 10'd0;
            wr_cnt   <= 14'd0;
            state    <= StActive;
          end
        end
        StActive: begin
          if (plk_rise && hs_s2) begin
            if (byte_cnt != 10'h3ff) byte_cnt <= byte_cnt + 10'd1;
            if (capture) begin
              o_Wr_En   <= 1'b1;
              o_Wr_Data <= d_p3;
              o_Wr_Addr <= addr_calc;
              if (wr_cnt != 14'h3fff) wr_cnt <= wr_cnt + 14'd1;
            end
          end
          if (hs_fall) begin
            if (row_cnt != 9'h1ff) row_cnt <= row_cnt + 9'd1;
            byte_cnt <= 10'd0;
          end
          if (vs_rise) state <= StDone;
        end
        StDone: begin
          o_Frame_Done <= 1'b1;
          o_Frame_Err  <= (wr_cnt != FRAME_SIZE);
          state        <= StVblank;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture: a small window keeps frames short; a second instance
// with Y_PHASE=1 sees the same sensor stream and must capture only the odd 8'hA5 bytes.
module tb_cam_frame_capture;

  localparam int unsigned IMG_W      = 12;
  localparam int unsigned IMG_H      = 8;
  localparam int unsigned COL_START  = 5;
  localparam int unsigned ROW_START  = 3;
  localparam int          LINE_BYTES = 48;
  localparam int          FULL       = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst_n, plk, vs, hs;
  logic [7:0]  d;
  logic        xlk0, wr_en0, done0, err0;
  logic [7:0]  wr_data0;
  logic [14:0] wr_addr0;
  logic        xlk1, wr_en1, done1, err1;
  logic [7:0]  wr_data1;
  logic [14:0] wr_addr1;

  int num_checks = 0;
  int num_errors = 0;
  int wr_cnt, wr_cnt1, done_cnt, done_cnt1, late_cnt, last_err;
  bit done_seen;

  initial forever #5 clk = ~clk;

  cam_frame_capture #(
    .XCLK_HALF(3), .IMG_W(IMG_W), .IMG_H(IMG_H), .COL_START(COL_START),
    .ROW_START(ROW_START), .Y_PHASE(0)
  ) u_dut0 (
    .Clk(clk), .i_Rst_n(rst_n), .i_PLK(plk), .i_VS(vs), .i_HS(hs), .i_D(d),
    .o_XLK(xlk0), .o_Wr_Data(wr_data0), .o_Wr_Addr(wr_addr0), .o_Wr_En(wr_en0),
    .o_Frame_Done(done0), .o_Frame_Err(err0)
  );

  cam_frame_capture #(
    .XCLK_HALF(3), .IMG_W(IMG_W), .IMG_H(IMG_H), .COL_START(COL_START),
    .ROW_START(ROW_START), .Y_PHASE(1)
  ) u_dut1 (
    .Clk(clk), .i_Rst_n(rst_n), .i_PLK(plk), .i_VS(vs), .i_HS(hs), .i_D(d),
    .o_XLK(xlk1), .o_Wr_Data(wr_data1), .o_Wr_Addr(wr_addr1), .o_Wr_En(wr_en1),
    .o_Frame_Done(done1), .o_Frame_Err(err1)
  );

  task automatic check(input string tag, input int got, input int exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    wr_cnt    = 0;
    wr_cnt1   = 0;
    done_cnt  = 0;
    done_cnt1 = 0;
    late_cnt  = 0;
    last_err  = 0;
    done_seen = 1'b0;
  endtask

  // Write monitor: addresses must run 0,1,2,... and data must equal the column value.
  initial begin
    clear_model();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_en0) begin
          check("wr_addr", int'(wr_addr0), wr_cnt);
          check("wr_data", int'(wr_data0), COL_START + (int'(wr_addr0) % IMG_W));
          if (done_seen) late_cnt++;
          wr_cnt++;
        end
        if (wr_en1) begin
          check("yphase1_data", int'(wr_data1), 8'hA5);
          check("yphase1_addr", int'(wr_addr1), wr_cnt1);
          wr_cnt1++;
        end
        if (done0) begin
          check("done_without_wr", int'(wr_en0), 0);
          done_cnt++;
          done_seen = 1'b1;
          last_err  = int'(err0);
        end
        if (done1) done_cnt1++;
      end
    end
  end

  // One PLK period of 6 Clk cycles; data changes on the PLK falling edge.
  task automatic plk_period(input logic [7:0] v);
    plk = 1'b0;
    d   = v;
    repeat (3) @(negedge clk);
    plk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic line(input bit end_vs);
    hs = 1'b1;
    for (int b = 0; b < LINE_BYTES; b++) plk_period(b[0] ? 8'hA5 : 8'(b >> 1));
    hs = 1'b0;
    if (end_vs) vs = 1'b1;
    repeat (3) plk_period(8'h00);
  endtask

  task automatic lines(input int n, input bit last_vs);
    for (int i = 0; i < n; i++) line(last_vs && (i == n - 1));
  endtask

  task automatic vs_blank();
    vs = 1'b1;
    repeat (4) plk_period(8'h00);
  endtask

  task automatic vs_low();
    vs = 1'b0;
    repeat (2) plk_period(8'h00);
  endtask

  task automatic check_frame(input string tag, input int exp_wr, input int exp_done,
                             input int exp_err);
    check({tag, "_writes"}, wr_cnt, exp_wr);
    check({tag, "_writes_y1"}, wr_cnt1, exp_wr);
    check({tag, "_done"}, done_cnt, exp_done);
    check({tag, "_done_y1"}, done_cnt1, exp_done);
    check({tag, "_err"}, last_err, exp_err);
    check({tag, "_late_writes"}, late_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    plk   = 1'b0;
    vs    = 1'b0;
    hs    = 1'b0;
    d     = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_xlk", int'(xlk0), 0);
    check("rst_wr_en", int'(wr_en0), 0);
    check("rst_wr_addr", int'(wr_addr0), 0);
    check("rst_wr_data", int'(wr_data0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_err", int'(err0), 0);

    // Master clock: toggles on the 3rd, 6th, 9th edge after release.
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("xclk_%0d", k), int'(xlk0), (k / 3) % 2);
    end

    // ARM -> VBLANK on the first blanking; no frame reported.
    vs_blank();
    check("arm_no_done", done_cnt, 0);

    clear_model();
    vs_low();
    lines(14, 1'b0);
    vs_blank();
    check_frame("full", FULL, 1, 0);

    // Reset during line 5, released before line 8: rows 3 and 4 only, no done.
    clear_model();
    vs_low();
    lines(5, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", int'(wr_en0), 0);
    check("midrst_done", int'(done0), 0);
    check("midrst_addr", int'(wr_addr0), 0);
    lines(3, 1'b0);
    rst_n = 1'b1;
    lines(6, 1'b0);
    vs_blank();
    check_frame("reset_frame", 2 * IMG_W, 0, 0);

    clear_model();
    vs_low();
    lines(14, 1'b0);
    vs_blank();
    check_frame("after_reset", FULL, 1, 0);

    // Short frame: 7 lines cover rows 3..6 only.
    clear_model();
    vs_low();
    lines(7, 1'b0);
    vs_blank();
    check_frame("short", 4 * IMG_W, 1, 1);

    clear_model();
    vs_low();
    lines(14, 1'b0);
    vs_blank();
    check_frame("after_short", FULL, 1, 0);

    // Last HS fall and VS rise on the same cycle: 11 lines -> row counter ends at 11.
    clear_model();
    vs_low();
    lines(11, 1'b1);
    vs_blank();
    check_frame("simul", FULL, 1, 0);
    check("simul_row", int'(u_dut0.row_cnt), 11);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
